vga_fb_scanout: RTL and testbench
=================================

// Module: vga_fb_scanout
// PURPOSE
//   Parametrised VGA timing generator with framebuffer scan-out. Generates porch/sync timing from
//   per-phase parameters, issues one read per active pixel to a dual-port framebuffer RAM with
//   configurable read latency and optional 2^N pixel replication. Realigns sync, blank and
//   coordinates to the returned data. Sits between the framebuffer RAM read port and the board VGA pins.
// PARAMETERS
//   PIXEL_BITS   4    bits per colour channel; fb_rd_data is {r,g,b}
//   CLK_DIV      2    clk cycles per pixel (>=1)
//   H_ACTIVE     640  visible pixels per line
//   H_FP/H_SYNC/H_BP  16/96/48  horizontal porch, sync and back-porch widths, in pixels
//   V_ACTIVE     480  visible lines
//   V_FP/V_SYNC/V_BP  10/2/33   vertical porch, sync and back-porch widths, in lines
//   HS_POL/VS_POL     0/0   sync active level (0 = active-low)
//   SCALE_LOG2   0    each framebuffer pixel is 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
//   RD_LATENCY   1    clk cycles from fb_rd_en high to fb_rd_data valid (>=1)
//   Derived: H_TOTAL=sum of H_*; V_TOTAL=sum of V_*; FB_W=H_ACTIVE>>SCALE_LOG2;
//   FB_H=V_ACTIVE>>SCALE_LOG2; ADDR_BITS=$clog2(FB_W*FB_H)
// PORTS
//   clk          in   1               system clock
//   rst          in   1               synchronous reset, active-high
//   fb_rd_en     out  1               framebuffer read strobe, one clk per active pixel
//   fb_addr      out  ADDR_BITS       framebuffer read address, row-major
//   fb_rd_data   in   3*PIXEL_BITS    {r,g,b}, valid RD_LATENCY clks after fb_rd_en
//   vga_r/g/b    out  PIXEL_BITS each pixel colour, 0 outside active area
//   h_sync       out  1               horizontal sync at HS_POL while asserted
//   v_sync       out  1               vertical sync at VS_POL while asserted
//   vga_de       out  1               high while the output pixel is in the active area
//   vga_x        out  $clog2(H_TOTAL) horizontal count of the current output pixel
//   vga_y        out  $clog2(V_TOTAL) vertical count of the current output pixel
//   frame_start  out  1               1-clk pulse when output pixel (0,0) first appears
// BEHAVIOUR
// - Divider: div_cnt counts 0..CLK_DIV-1. pix_ce=(div_cnt==CLK_DIV-1). CLK_DIV=1 gives pix_ce every clk.
// - Counters: on pix_ce, h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
//   v_cnt wraps to 0 at V_TOTAL-1.
// - Decode from counters: active=(h<H_ACTIVE)&&(v<V_ACTIVE).
//   hs=(h>=H_ACTIVE+H_FP)&&(h<H_ACTIVE+H_FP+H_SYNC). vs: same form on v with the V_* parameters.
// - Addressing is multiplier-free. row_base holds the start address of the current fb row.
//   row_base += FB_W when v wraps to the next fb row (every 2^SCALE_LOG2 lines within active).
//   row_base clears to 0 at v_cnt wrap.
//   fb_addr = row_base + (h_cnt>>SCALE_LOG2).
// - Read issue: fb_addr and fb_rd_en are registered. fb_rd_en=1 for exactly one clk per active
//   pixel, in the clk after the counters first present that pixel (div_cnt==0). fb_rd_en=0 in blanking.
//   Replicated pixels re-read the same address; no read caching.
// - Alignment: hs, vs, active, h_cnt, v_cnt pass through a delay line so that every output sees a
//   fixed latency L=RD_LATENCY+2 clks from counter to pin.
//   Each pixel value is held for CLK_DIV clks.
//   The rgb output register captures fb_rd_data when the delayed active and read-valid are both high.
//   It loads 0 when the delayed active is low.
// - Sync outputs are driven at the polarity level while asserted, at the inverse level otherwise.
// - frame_start=1 for one clk on the first clk that the output shows x=0,y=0.
// - Reset, on any cycle including mid-frame, returns the block to the state below and restarts
//   from (0,0) on the next clk:
//   div_cnt=h_cnt=v_cnt=row_base=0; delay line cleared to the inactive state;
//   fb_rd_en=0, fb_addr=0, rgb=0, vga_de=0, vga_x=vga_y=0, frame_start=0;
//   h_sync=!HS_POL, v_sync=!VS_POL.
// - During the first L clks after reset, only the reset values above appear on the outputs.
// TESTING (small timing: H 8/2/3/3, V 4/1/2/1, CLK_DIV=1, RD_LATENCY=1, RAM model returns data=addr)
// - Sync timing -> h_sync period 16 clks, low for 3 clks starting when vga_x=10.
//   v_sync low for 2 lines starting when vga_y=5. Frame period 128 clks; frame_start every 128 clks.
// - Scan-out data -> line 0 rgb = 0..7, line 3 rgb = 24..31, rgb=0 and vga_de=0 in all blanking.
//   First pixel appears 3 clks after the counters reach (0,0).
// - SCALE_LOG2=1 -> fb_addr sequence is 0,0,1,1,2,2,3,3 on lines 0 and 1, and 4,4,...,7,7 on lines 2 and 3.
//   Screen shows a 4x2 image, each pixel doubled.
// - CLK_DIV=2, RD_LATENCY=3 -> each pixel held 2 clks. fb_rd_en pulses every 2 clks during active.
//   Latency is 5 clks. h_sync period is 32 clks.
// - HS_POL=1, VS_POL=1 -> syncs idle low, pulse high with the same widths. Reset value is 0.
// - Assert rst for 1 clk mid-line at pixel (5,2) -> the next clk shows all reset values.
//   frame_start fires exactly 3 clks after rst deasserts; no stale rgb or fb_rd_en appears.

Source files
------------

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port between the VGA scan-out (master) and the framebuffer RAM (slave).
interface vga_fb_scanout_if #(
  parameter int ADDR_BITS  = 19,
  parameter int PIXEL_BITS = 4
);
  logic                    fb_rd_en;
  logic [ADDR_BITS-1:0]    fb_addr;
  logic [3*PIXEL_BITS-1:0] fb_rd_data;

  modport master (output fb_rd_en, fb_addr, input fb_rd_data);
  modport slave  (input fb_rd_en, fb_addr, output fb_rd_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA timing generator with framebuffer scan-out; sync, blank and coordinates are
// delayed so they reach the pins together with the pixel data read from the RAM.
module vga_fb_scanout #(
  parameter int PIXEL_BITS = 4,
  parameter int CLK_DIV    = 2,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int SCALE_LOG2 = 0,
  parameter int RD_LATENCY = 1,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int FB_W      = H_ACTIVE >> SCALE_LOG2,
  localparam int FB_H      = V_ACTIVE >> SCALE_LOG2,
  localparam int ADDR_BITS = $clog2(FB_W * FB_H),
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  rst,
  vga_fb_scanout_if.master      fb,
  output logic [PIXEL_BITS-1:0] vga_r,
  output logic [PIXEL_BITS-1:0] vga_g,
  output logic [PIXEL_BITS-1:0] vga_b,
  output logic                  h_sync,
  output logic                  v_sync,
  output logic                  vga_de,
  output logic [HW-1:0]         vga_x,
  output logic [VW-1:0]         vga_y,
  output logic                  frame_start
);

  // Counter-to-pin latency: one clk for the read issue register, RD_LATENCY for the RAM, one for rgb.
  localparam int L  = RD_LATENCY + 2;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0]        DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]        H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]        H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]        HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]        HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]        V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]        V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]        VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]        VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]        ROW_MASK = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(FB_W);

  logic [DW-1:0]        div_cnt;
  logic [HW-1:0]        h_cnt;
  logic [VW-1:0]        v_cnt;
  logic [ADDR_BITS-1:0] row_base;
  logic                 pix_ce, active, hs, vs, first_pix, issue, origin;

  assign pix_ce    = (div_cnt == DIV_LAST);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs        = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs        = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign first_pix = (div_cnt == '0);
  assign issue     = active && first_pix;
  assign origin    = first_pix && (h_cnt == '0) && (v_cnt == '0);

  // row_base advances after the last screen line of each framebuffer row, avoiding a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      row_base <= '0;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
      if (pix_ce) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) begin
            v_cnt    <= '0;
            row_base <= '0;
          end else begin
            v_cnt <= v_cnt + 1'b1;
            if ((v_cnt < V_ACT) && ((v_cnt & ROW_MASK) == ROW_MASK))
              row_base <= row_base + ROW_STEP;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb.fb_rd_en <= 1'b0;
      fb.fb_addr  <= '0;
    end else begin
      fb.fb_rd_en <= issue;
      if (issue)
        fb.fb_addr <= row_base + ADDR_BITS'(h_cnt >> SCALE_LOG2);
    end
  end

  logic [L-1:0]          act_d, hs_d, vs_d, fs_d;
  logic [HW-1:0]         x_d [L];
  logic [VW-1:0]         y_d [L];
  logic [RD_LATENCY-1:0] rv_d;

  // Sync levels are stored already polarised so the pins come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_d <= '0;
      hs_d  <= {L{~HS_POL}};
      vs_d  <= {L{~VS_POL}};
      fs_d  <= '0;
      rv_d  <= '0;
      for (int i = 0; i < L; i++) begin
        x_d[i] <= '0;
        y_d[i] <= '0;
      end
    end else begin
      act_d  <= {act_d[L-2:0], active};
      hs_d   <= {hs_d[L-2:0], hs ? HS_POL : ~HS_POL};
      vs_d   <= {vs_d[L-2:0], vs ? VS_POL : ~VS_POL};
      fs_d   <= {fs_d[L-2:0], origin};
      rv_d   <= RD_LATENCY'({rv_d, fb.fb_rd_en});
      x_d[0] <= h_cnt;
      y_d[0] <= v_cnt;
      for (int i = 1; i < L; i++) begin
        x_d[i] <= x_d[i-1];
        y_d[i] <= y_d[i-1];
      end
    end
  end

  logic [3*PIXEL_BITS-1:0] rgb;

  // Read data is captured once per pixel and held for the remaining clks of that pixel.
  always_ff @(posedge clk) begin
    if (rst || !act_d[L-2])
      rgb <= '0;
    else if (rv_d[RD_LATENCY-1])
      rgb <= fb.fb_rd_data;
  end

  assign {vga_r, vga_g, vga_b} = rgb;
  assign vga_de      = act_d[L-1];
  assign h_sync      = hs_d[L-1];
  assign v_sync      = vs_d[L-1];
  assign frame_start = fs_d[L-1];
  assign vga_x       = x_d[L-1];
  assign vga_y       = y_d[L-1];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: two configurations on small timing, random framebuffer contents
// and random resets, checked every clk against a frame-arithmetic reference model.
module tb_vga_fb_scanout;

  localparam int PB  = 4;
  localparam int HA  = 8, HF = 2, HSW = 3, HB = 3;
  localparam int VA  = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT  = HA + HF + HSW + HB;
  localparam int VT  = VA + VF + VSW + VB;

  localparam int A_DIV = 1, A_LAT = 1, A_SC = 0;
  localparam bit A_POL = 1'b0;
  localparam int B_DIV = 2, B_LAT = 3, B_SC = 1;
  localparam bit B_POL = 1'b1;
  localparam int A_AB  = $clog2((HA >> A_SC) * (VA >> A_SC));
  localparam int B_AB  = $clog2((HA >> B_SC) * (VA >> B_SC));

  typedef struct packed {
    int rd_en; int addr; int de; int hs; int vs; int fs; int x; int y; int pix;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_fb_scanout_if #(.ADDR_BITS(A_AB), .PIXEL_BITS(PB)) fa ();
  vga_fb_scanout_if #(.ADDR_BITS(B_AB), .PIXEL_BITS(PB)) fbb ();

  logic [PB-1:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic          a_hs, a_vs, a_de, a_fs, b_hs, b_vs, b_de, b_fs;
  logic [3:0]    a_x, b_x;
  logic [2:0]    a_y, b_y;

  vga_fb_scanout #(
    .PIXEL_BITS(PB), .CLK_DIV(A_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(A_POL), .VS_POL(A_POL), .SCALE_LOG2(A_SC), .RD_LATENCY(A_LAT)
  ) dut_a (
    .clk(clk), .rst(rst), .fb(fa),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
    .h_sync(a_hs), .v_sync(a_vs), .vga_de(a_de),
    .vga_x(a_x), .vga_y(a_y), .frame_start(a_fs)
  );

  vga_fb_scanout #(
    .PIXEL_BITS(PB), .CLK_DIV(B_DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(B_POL), .VS_POL(B_POL), .SCALE_LOG2(B_SC), .RD_LATENCY(B_LAT)
  ) dut_b (
    .clk(clk), .rst(rst), .fb(fbb),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
    .h_sync(b_hs), .v_sync(b_vs), .vga_de(b_de),
    .vga_x(b_x), .vga_y(b_y), .frame_start(b_fs)
  );

  // RAM models return random junk when no read was issued, so a mistimed capture shows up.
  logic [3*PB-1:0] mem_a [32];
  logic [3*PB-1:0] mem_b [8];
  logic [3*PB-1:0] pipe_a [A_LAT];
  logic [3*PB-1:0] pipe_b [B_LAT];

  always @(posedge clk) begin
    pipe_a[0] <= fa.fb_rd_en ? mem_a[fa.fb_addr] : (3*PB)'($urandom);
    for (int i = 1; i < A_LAT; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b[0] <= fbb.fb_rd_en ? mem_b[fbb.fb_addr] : (3*PB)'($urandom);
    for (int i = 1; i < B_LAT; i++) pipe_b[i] <= pipe_b[i-1];
  end

  assign fa.fb_rd_data  = pipe_a[A_LAT-1];
  assign fbb.fb_rd_data = pipe_b[B_LAT-1];

  // n = clks since the last reset edge; counters sit at pixel-clock time n.
  function automatic exp_t model(input int div, input int lat, input int sc, input int pol, input int n);
    exp_t e;
    int c, p, h, v, l;
    l = lat + 2;
    e = '0;
    e.hs = 1 - pol;
    e.vs = 1 - pol;
    e.pix = -1;
    if (n >= 1) begin
      c = n - 1;
      p = c / div;
      h = p % HT;
      v = (p / HT) % VT;
      if ((c % div == 0) && h < HA && v < VA) begin
        e.rd_en = 1;
        e.addr  = (v >> sc) * (HA >> sc) + (h >> sc);
      end
    end
    if (n >= l) begin
      c = n - l;
      p = c / div;
      h = p % HT;
      v = (p / HT) % VT;
      e.de = (h < HA && v < VA) ? 1 : 0;
      e.hs = (h >= HA + HF && h < HA + HF + HSW) ? pol : 1 - pol;
      e.vs = (v >= VA + VF && v < VA + VF + VSW) ? pol : 1 - pol;
      e.fs = (p % (HT * VT) == 0 && c % div == 0) ? 1 : 0;
      e.x  = h;
      e.y  = v;
      if (e.de == 1) e.pix = (v >> sc) * (HA >> sc) + (h >> sc);
    end
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cyc %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkInst(input string id, input int which, input int div, input int lat,
                           input int sc, input int pol, input logic rd_en, input logic [31:0] addr,
                           input logic [3*PB-1:0] rgb, input logic de, input logic hs,
                           input logic vs, input logic fs, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [3*PB-1:0] exp_rgb;
    e = model(div, lat, sc, pol, cyc);
    exp_rgb = '0;
    if (e.pix >= 0) exp_rgb = (which == 0) ? mem_a[e.pix[4:0]] : mem_b[e.pix[2:0]];
    checkOutput({id, ".rd_en"}, 32'(rd_en), e.rd_en);
    if (e.rd_en == 1 || cyc == 0) checkOutput({id, ".addr"}, addr, e.addr);
    checkOutput({id, ".rgb"}, 32'(rgb), 32'(exp_rgb));
    checkOutput({id, ".de"}, 32'(de), e.de);
    checkOutput({id, ".hsync"}, 32'(hs), e.hs);
    checkOutput({id, ".vsync"}, 32'(vs), e.vs);
    checkOutput({id, ".fstart"}, 32'(fs), e.fs);
    checkOutput({id, ".x"}, x, e.x);
    checkOutput({id, ".y"}, y, e.y);
  endtask

  task automatic applyStimulus(input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r;
      @(posedge clk);
      if (r) cyc = 0;
      else cyc++;
      @(negedge clk);
      checkInst("A", 0, A_DIV, A_LAT, A_SC, int'(A_POL), fa.fb_rd_en, 32'(fa.fb_addr),
                {a_r, a_g, a_b}, a_de, a_hs, a_vs, a_fs, 32'(a_x), 32'(a_y));
      checkInst("B", 1, B_DIV, B_LAT, B_SC, int'(B_POL), fbb.fb_rd_en, 32'(fbb.fb_addr),
                {b_r, b_g, b_b}, b_de, b_hs, b_vs, b_fs, 32'(b_x), 32'(b_y));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_a[i] = (3*PB)'($urandom);
    for (int i = 0; i < 8; i++)  mem_b[i] = (3*PB)'($urandom);

    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 600);

    // Single-clk reset while instance A's counters are at pixel (5,2).
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 2 * HT + 5);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 300);

    repeat (6) begin
      applyStimulus(1'b0, $urandom_range(20, 400));
      applyStimulus(1'b1, $urandom_range(1, 3));
    end
    applyStimulus(1'b0, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
